// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    // 1 when the received parity bit disagrees with the payload for the chosen parity type
    function automatic logic par_mismatch(input logic par_bit, input logic data_xor,
                                          input logic par_typ);
        return par_bit ^ data_xor ^ par_typ;
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample edge counter and bit counter; eob_c marks the last oversample of a bit.
module edge_bit_counter #(
    parameter int unsigned PRESC_W   = 6,
    parameter int unsigned BIT_CNT_W = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [PRESC_W-1:0]   presc_q,
    output logic [PRESC_W-1:0]   edge_count,
    output logic [BIT_CNT_W-1:0] bit_count,
    output logic                 eob_c
);

    assign eob_c = enable && (edge_count == presc_q - PRESC_W'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!enable || clear) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (eob_c) begin
            edge_count <= '0;
            bit_count  <= bit_count + BIT_CNT_W'(1);
        end else begin
            edge_count <= edge_count + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: start/data/parity/stop checking and payload handoff.
// Define UART_RX_ERR_CNT_EN to add the saturating err_count output.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESC_W    = 6,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S_DATA,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [PRESC_W-1:0]    edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    rx_state_e             state;
    logic [PRESC_W-1:0]    presc_q;
    logic [DATA_WIDTH-1:0] shift;
    logic [BIT_CNT_W-1:0]  bit_count;
    logic                  perr_q;
    logic                  eob_c;
    logic                  serr_c;
    logic                  restart_c;

    assign serr_c = ~sampled_bit;
    // A falling S_DATA in IDLE or at the stop-bit end opens a new frame
    assign restart_c = !S_DATA && ((state == IDLE) || (state == STOP && eob_c));

    edge_bit_counter #(
        .PRESC_W   (PRESC_W),
        .BIT_CNT_W (BIT_CNT_W)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (dat_samp_en),
        .clear      (restart_c),
        .presc_q    (presc_q),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .eob_c      (eob_c)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            presc_q     <= '0;
            shift       <= '0;
            perr_q      <= 1'b0;
            dat_samp_en <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    dat_samp_en <= 1'b0;
                    if (!S_DATA) begin
                        state       <= START;
                        presc_q     <= Prescale;
                        perr_q      <= 1'b0;
                        dat_samp_en <= 1'b1;
                    end
                end
                START: if (eob_c) begin
                    if (!sampled_bit) begin
                        state <= DATA;
                    end else begin
                        state       <= IDLE;
                        dat_samp_en <= 1'b0;
                    end
                end
                // LSB arrives first, so shifting in from the top leaves it at bit 0
                DATA: if (eob_c) begin
                    shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
                    if (bit_count == BIT_CNT_W'(DATA_WIDTH)) begin
                        state <= PAR_EN ? PARITY : STOP;
                    end
                end
                PARITY: if (eob_c) begin
                    perr_q <= par_mismatch(sampled_bit, ^shift, PAR_TYP);
                    state  <= STOP;
                end
                STOP: if (eob_c) begin
                    par_err <= perr_q;
                    stp_err <= serr_c;
                    if (!perr_q && !serr_c) begin
                        P_DATA     <= shift;
                        data_valid <= 1'b1;
                    end
                    if (!S_DATA) begin
                        state   <= START;
                        presc_q <= Prescale;
                        perr_q  <= 1'b0;
                    end else begin
                        state       <= IDLE;
                        dat_samp_en <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    dat_samp_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // Rejected-frame counter, saturating
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_count <= '0;
        end else if (state == STOP && eob_c && (perr_q || serr_c) && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART RX path.
- Owns the frame FSM and the edge/bit counters, and drives the enable and `edge_count` of the 3-sample majority-vote data sampler. The sampler updates `sampled_bit` one cycle after `edge_count == Prescale/2+1`.
- Consumes `sampled_bit`, deserializes LSB-first, checks start/parity/stop, and presents `P_DATA`/`data_valid` to the system controller in the UART_CLK domain.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESC_W, 6, width of Prescale and edge counter.
- BIT_CNT_W, 4, width of bit counter (must cover DATA_WIDTH+3).

Ports:
- CLK  in  1  UART RX oversampling clock
- RST  in  1  asynchronous, active-low reset
- S_DATA  in  1  synchronized serial input, idle high
- Prescale  in  PRESC_W  oversampling ratio; legal 8, 16, 32
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- sampled_bit  in  1  majority-voted bit from sampler
- dat_samp_en  out  1  sampler Enable
- edge_count  out  PRESC_W  oversample index within current bit, to sampler
- P_DATA  out  DATA_WIDTH  received payload
- data_valid  out  1  one-cycle pulse: frame accepted
- par_err  out  1  parity error flag for last frame
- stp_err  out  1  stop error flag for last frame

Behaviour:
- Reset: async, active-low. State = IDLE; `edge_count`, bit counter, shift register, `P_DATA`, `data_valid`, `par_err`, `stp_err`, `dat_samp_en` = 0.
- Prescale capture: Prescale is latched into `presc_q` on IDLE→START. Changes mid-frame have no effect until the next frame.
- Counters: run only when `dat_samp_en` = 1 (all states except IDLE).
  - `edge_count` increments every cycle and wraps at `presc_q-1` → 0.
  - On wrap, the bit counter increments.
  - `edge_count` and the bit counter are cleared in IDLE.
- Bit end: "end-of-bit" (EOB) is the cycle with `edge_count == presc_q-1`. `sampled_bit` is stable at EOB for every legal Prescale.
- IDLE:
  - `dat_samp_en` = 0.
  - S_DATA = 0 → START; `edge_count` = 0 on entry.
- START, at EOB:
  - `sampled_bit` = 0 → DATA.
  - Otherwise (glitch) → IDLE, with no flags changed.
- DATA:
  - At each EOB, `shift[bit_idx] <= sampled_bit`, LSB first.
  - After DATA_WIDTH bits → PARITY if PAR_EN, else STOP.
- PARITY, at EOB:
  - Compute `perr = sampled_bit ^ (^shift) ^ PAR_TYP`.
  - → STOP.
  - If PAR_EN = 0, perr = 0.
- STOP, at EOB:
  - `serr = ~sampled_bit`.
  - `par_err <= perr` and `stp_err <= serr`; both are held until the next STOP EOB.
  - If `!perr && !serr`: `P_DATA <= shift` and `data_valid` pulses high for exactly the next cycle. Otherwise `P_DATA` is unchanged and there is no pulse.
  - Next state: S_DATA = 0 → START (back-to-back frame, `edge_count` = 0, Prescale re-latched); else → IDLE.
- Latency: `data_valid` rises 1 cycle after the stop-bit EOB, i.e. `(DATA_WIDTH + 2 + PAR_EN) * presc_q` cycles after START entry.
- Sampler enable: `dat_samp_en` drops to 0 in IDLE, which clears the sampler; this is required so stale votes never carry between frames.
- Reset mid-frame: immediate return to IDLE. No `data_valid` pulse; flags cleared.
- Width rules: `edge_count` compare uses PRESC_W-bit unsigned arithmetic.

Optional Feature:
- Macro: UART_RX_ERR_CNT_EN.
- When defined:
  - Extra output `err_count` [7:0].
  - Increments by 1 at each STOP EOB where `perr | serr`, saturating at 255.
  - Cleared only by RST.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `uart_rx_pkg` holds:
  - FSM state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits.
  - PAR_EVEN = 0 and PAR_ODD = 1 constants.
  - Legal Prescale constants 8/16/32.
- One natural sub-module, `edge_bit_counter`:
  - Inputs: enable, `presc_q`.
  - Outputs: `edge_count`, bit count, EOB strobe.
- FSM, deserializer and checkers stay in the top.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity bit 0, stop 1 → `P_DATA` = 0xA5, `data_valid` pulses 1 cycle at 88 cycles after start entry, `par_err` = 0, `stp_err` = 0.
- Same frame with parity bit 1 → no `data_valid`, `par_err` = 1, `P_DATA` keeps previous value.
- Prescale=16, PAR_EN=0, 0x3C with stop bit 0 → `stp_err` = 1, no pulse; next good frame 0x55 → `data_valid`, `stp_err` = 0.
- Start glitch: S_DATA low for 3 cycles at Prescale=8 → return to IDLE after 8 cycles, no flag change, `dat_samp_en` = 0.
- Back-to-back frames 0x01 then 0xFE at Prescale=32, PAR_EN=0, no idle gap → two `data_valid` pulses 320 cycles apart, correct data.
- RST asserted during DATA bit 4 → all outputs 0 immediately; following frame 0x7E received correctly. With UART_RX_ERR_CNT_EN, 3 bad frames → `err_count` = 3.
